// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
// Two requesters share one 32-bit shift datapath. Arbitration is round-robin
// and only one operation is in flight at a time. The registered result is
// held until the requester that owns it accepts it.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (N = 0, 1)
//   reqN_x, reqN_sc, reqN_op  operand, shift count, op (0 LSL, 1 ASR, 2 ROR, 3 LSR)
//   rspN_valid / rspN_ready   response handshake for requester N
//   rspN_y                    result for requester N
//   stall0, stall1            saturating stall counters (SHIFT_ARB_STATS_EN only)
//
// Optional build macro: SHIFT_ARB_STATS_EN adds the stall0/stall1 counters.
module shift_unit_arbiter #(
    parameter int unsigned W       = 32,
    parameter bit          RR_INIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_x,
    input  logic [4:0]   req0_sc,
    input  logic [1:0]   req0_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_x,
    input  logic [4:0]   req1_sc,
    input  logic [1:0]   req1_op,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_y
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]  stall0,
    output logic [15:0]  stall1
`endif
);

    localparam int unsigned SCW = 5;
    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OP_LSL = 2'd0;
    localparam logic [OPW-1:0] OP_ASR = 2'd1;
    localparam logic [OPW-1:0] OP_ROR = 2'd2;
    localparam logic [OPW-1:0] OP_LSR = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e         state_q;
    logic           owner_q;      // requester that owns the held result
    logic           last_q;       // last-granted requester
    logic           rsp0_valid_q;
    logic           rsp1_valid_q;
    logic [W-1:0]   rsp0_y_q;
    logic [W-1:0]   rsp1_y_q;

    logic           grant0;
    logic           grant1;
    logic           owner_ready;
    logic           slot_free;
    logic           accept0;
    logic           accept1;

    logic [W-1:0]   sel_x;
    logic [SCW-1:0] sel_sc;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   stage1;
    logic [W-1:0]   stage2;
    logic [W-1:0]   shift_res_d;

    // One log-shifter step by a fixed amount k (k >= 1) for the given op.
    function automatic logic [W-1:0] shift_k(input logic [W-1:0]   v,
                                             input logic [OPW-1:0] op,
                                             input int unsigned    k);
        logic [W-1:0] r;
        case (op)
            OP_LSL:  r = v << k;
            OP_ASR:  r = W'($signed(v) >>> k);
            OP_ROR:  r = (v >> k) | (v << (W - k));
            OP_LSR:  r = v >> k;
            default: r = v;
        endcase
        return r;
    endfunction

    // Round-robin grant: on a tie the requester that was not granted last wins.
    always_comb begin
        grant0      = req0_valid & (~req1_valid | last_q);
        grant1      = req1_valid & (~req0_valid | ~last_q);
        owner_ready = owner_q ? rsp1_ready : rsp0_ready;
        slot_free   = (state_q == IDLE) | ((state_q == HOLD) & owner_ready);
        req0_ready  = ~rst & grant0 & slot_free;
        req1_ready  = ~rst & grant1 & slot_free;
        accept0     = req0_valid & req0_ready;
        accept1     = req1_valid & req1_ready;
    end

    // Operand mux and the radix-4 / radix-4 / 16 log-shifter.
    always_comb begin
        sel_x  = grant1 ? req1_x  : req0_x;
        sel_sc = grant1 ? req1_sc : req0_sc;
        sel_op = grant1 ? req1_op : req0_op;

        case (sel_sc[1:0])
            2'd1:    stage1 = shift_k(sel_x, sel_op, 1);
            2'd2:    stage1 = shift_k(sel_x, sel_op, 2);
            2'd3:    stage1 = shift_k(sel_x, sel_op, 3);
            default: stage1 = sel_x;
        endcase

        case (sel_sc[3:2])
            2'd1:    stage2 = shift_k(stage1, sel_op, 4);
            2'd2:    stage2 = shift_k(stage1, sel_op, 8);
            2'd3:    stage2 = shift_k(stage1, sel_op, 12);
            default: stage2 = stage1;
        endcase

        shift_res_d = sel_sc[4] ? shift_k(stage2, sel_op, 16) : stage2;
    end

    // Control FSM and result registers. A new accept while the owner drains
    // its result keeps the FSM in HOLD, giving one operation per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= RR_INIT;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_y_q     <= '0;
            rsp1_y_q     <= '0;
        end else begin
            if (accept0 | accept1) begin
                state_q      <= HOLD;
                owner_q      <= accept1;
                last_q       <= accept1;
                rsp0_valid_q <= accept0;
                rsp1_valid_q <= accept1;
                if (accept0) begin
                    rsp0_y_q <= shift_res_d;
                end else begin
                    rsp1_y_q <= shift_res_d;
                end
            end else if ((state_q == HOLD) && owner_ready) begin
                state_q      <= IDLE;
                rsp0_valid_q <= 1'b0;
                rsp1_valid_q <= 1'b0;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_y     = rsp0_y_q;
    assign rsp1_y     = rsp1_y_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] stall0_q;
    logic [15:0] stall1_q;

    // Saturating count of cycles a requester waits with valid asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else begin
            if (req0_valid && !req0_ready && (stall0_q != 16'hFFFF)) begin
                stall0_q <= stall0_q + 16'd1;
            end
            if (req1_valid && !req1_ready && (stall1_q != 16'hFFFF)) begin
                stall1_q <= stall1_q + 16'd1;
            end
        end
    end

    assign stall0 = stall0_q;
    assign stall1 = stall1_q;
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Testbench for shift_unit_arbiter: directed vectors with hand-computed
// results, a response scoreboard per port and a grant-order log.
// Build with SHIFT_ARB_STATS_EN defined to also exercise the stall counters.
module tb_shift_unit_arbiter;

    localparam logic [1:0] OP_LSL = 2'd0;
    localparam logic [1:0] OP_ASR = 2'd1;
    localparam logic [1:0] OP_ROR = 2'd2;
    localparam logic [1:0] OP_LSR = 2'd3;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req0_x, req1_x, rsp0_y, rsp1_y;
    logic [4:0]  req0_sc, req1_sc;
    logic [1:0]  req0_op, req1_op;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] stall0, stall1;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int both_ready_cnt = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          log_id[$];
    int          log_cyc[$];
    logic        log_en = 1'b0;

    logic        p0_pend = 1'b0, p1_pend = 1'b0;
    logic [38:0] p0_fields, p1_fields;

    shift_unit_arbiter #(.W(32), .RR_INIT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_sc    (req0_sc),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_y     (rsp0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_sc    (req1_sc),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_y     (rsp1_y)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stall0     (stall0),
        .stall1     (stall1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation on port p and push its expected result on accept.
    task automatic issue(input int p, input logic [31:0] x, input logic [4:0] sc,
                         input logic [1:0] op, input logic [31:0] exp);
        int   n;
        logic rdy;
        n = 0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_x = x; req0_sc = sc; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_x = x; req1_sc = sc; req1_op = op;
        end
        do begin
            @(negedge clk);
            rdy = (p == 0) ? req0_ready : req1_ready;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL req%0d_accept_timeout: got no ready expected ready within 50 cycles", p);
        end else if (p == 0) begin
            exp0.push_back(exp);
        end else begin
            exp1.push_back(exp);
        end
        step();
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Reset drops any in-flight result, so pending expectations go too.
    task automatic do_reset(input int n);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp0.delete();
        exp1.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: scoreboard pops, grant log, single-ready and hold-stable checks.
    always @(negedge clk) begin
        if (rst) begin
            p0_pend = 1'b0;
            p1_pend = 1'b0;
        end else begin
            if (req0_ready && req1_ready) both_ready_cnt++;
            if (log_en && req0_valid && req0_ready) begin log_id.push_back(0); log_cyc.push_back(cyc); end
            if (log_en && req1_valid && req1_ready) begin log_id.push_back(1); log_cyc.push_back(cyc); end
            if (rsp0_valid && rsp0_ready) begin
                if (exp0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp0_unexpected: got %h expected no response", rsp0_y);
                end else chk("rsp0_y", rsp0_y, exp0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp1_unexpected: got %h expected no response", rsp1_y);
                end else chk("rsp1_y", rsp1_y, exp1.pop_front());
            end
            if (p0_pend) chk("req0_hold_stable", 32'({req0_valid, req0_x} == {1'b1, p0_fields[38:7]}
                                                    && {req0_sc, req0_op} == p0_fields[6:0]), 32'd1);
            if (p1_pend) chk("req1_hold_stable", 32'({req1_valid, req1_x} == {1'b1, p1_fields[38:7]}
                                                    && {req1_sc, req1_op} == p1_fields[6:0]), 32'd1);
            p0_pend   = req0_valid && !req0_ready;
            p1_pend   = req1_valid && !req1_ready;
            p0_fields = {req0_x, req0_sc, req0_op};
            p1_fields = {req1_x, req1_sc, req1_op};
        end
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_x = '0; req0_sc = '0; req0_op = OP_LSL;
        req1_valid = 1'b1; req1_x = '0; req1_sc = '0; req1_op = OP_LSL;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state with both requesters valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_y", rsp0_y, 32'h0);
        chk("rst_rsp1_y", rsp1_y, 32'h0);
        step();
        do_reset(1);

        // Requester 0 alone, with latency check.
        issue(0, 32'h0000_0001, 5'd31, OP_LSL, 32'h8000_0000);
        @(negedge clk);
        chk("latency_rsp0_valid", 32'(rsp0_valid), 32'd1);
        step();
        issue(0, 32'h8000_0000, 5'd4,  OP_ASR, 32'hF800_0000);
        issue(0, 32'h1234_5678, 5'd7,  OP_LSL, 32'h1A2B_3C00);
        issue(0, 32'h8000_0001, 5'd5,  OP_ASR, 32'hFC00_0000);
        issue(0, 32'h7FFF_FFFF, 5'd31, OP_ASR, 32'h0000_0000);

        // Requester 1 alone, including sc=0 for every op.
        issue(1, 32'h1234_5678, 5'd8,  OP_ROR, 32'h7812_3456);
        issue(1, 32'h8000_0000, 5'd31, OP_LSR, 32'h0000_0001);
        issue(1, 32'h1234_5678, 5'd20, OP_ROR, 32'h4567_8123);
        issue(1, 32'h1234_5678, 5'd13, OP_LSR, 32'h0000_91A2);
        issue(1, 32'hFFFF_0000, 5'd16, OP_ASR, 32'hFFFF_FFFF);
        issue(1, 32'h0000_0001, 5'd1,  OP_ROR, 32'h8000_0000);
        issue(1, 32'hDEAD_BEEF, 5'd0,  OP_LSL, 32'hDEAD_BEEF);
        issue(1, 32'hDEAD_BEEF, 5'd0,  OP_ASR, 32'hDEAD_BEEF);
        issue(1, 32'hDEAD_BEEF, 5'd0,  OP_ROR, 32'hDEAD_BEEF);
        issue(1, 32'hDEAD_BEEF, 5'd0,  OP_LSR, 32'hDEAD_BEEF);
        repeat (3) step();

        // Both valid every cycle from reset: grants alternate 0,1,... one per cycle.
        do_reset(2);
        log_id.delete(); log_cyc.delete(); log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue(0, 32'h0000_0001, 5'(i), OP_LSL, 32'h0000_0001 << i);
            end
            begin
                for (int i = 0; i < 4; i++)
                    issue(1, 32'h8000_0000, 5'(i), OP_LSR, 32'h8000_0000 >> i);
            end
        join
        log_en = 1'b0;
        repeat (3) step();
        chk("alt_grant_count", 32'(log_id.size()), 32'd8);
        for (int i = 0; i < log_id.size(); i++)
            chk($sformatf("alt_grant%0d", i), 32'(log_id[i]), 32'(i % 2));
        for (int i = 1; i < log_cyc.size(); i++)
            chk($sformatf("alt_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);

        // Owner stalls its response for 5 cycles while requester 1 waits.
        do_reset(1);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        issue(0, 32'hA5A5_A5A5, 5'd4, OP_ROR, 32'h5A5A_5A5A);
        req1_valid = 1'b1; req1_x = 32'h8000_0000; req1_sc = 5'd31; req1_op = OP_ASR;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp0_valid", 32'(rsp0_valid), 32'd1);
            chk("hold_rsp1_valid", 32'(rsp1_valid), 32'd0);
            chk("hold_rsp0_y", rsp0_y, 32'h5A5A_5A5A);
            chk("hold_req0_ready", 32'(req0_ready), 32'd0);
            chk("hold_req1_ready", 32'(req1_ready), 32'd0);
        end
        step();
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("b2b_req1_ready", 32'(req1_ready), 32'd1);
`ifdef SHIFT_ARB_STATS_EN
        chk("stall1_count", 32'(stall1), 32'd5);
        chk("stall0_count", 32'(stall0), 32'd0);
`endif
        if (req1_ready) exp1.push_back(32'hFFFF_FFFF);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("b2b_rsp0_valid", 32'(rsp0_valid), 32'd0);
        repeat (3) step();

        // Reset while holding a result owned by requester 0.
        rsp0_ready = 1'b0;
        issue(0, 32'h0000_00FF, 5'd8, OP_LSL, 32'h0000_FF00);
        do_reset(1);
        @(negedge clk);
        chk("rsthold_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rsthold_rsp0_y", rsp0_y, 32'h0);
        step();
        rsp0_ready = 1'b1;
        log_id.delete(); log_cyc.delete(); log_en = 1'b1;
        fork
            issue(0, 32'h0000_0003, 5'd30, OP_ROR, 32'h0000_000C);
            issue(1, 32'hF000_0000, 5'd28, OP_LSR, 32'h0000_000F);
        join
        log_en = 1'b0;
        repeat (3) step();
        chk("rsthold_first_grant", (log_id.size() > 0) ? 32'(log_id[0]) : 32'hFFFF_FFFF, 32'd0);

`ifdef SHIFT_ARB_STATS_EN
        // Stall counter saturates rather than wrapping.
        do_reset(1);
        rsp0_ready = 1'b0;
        issue(0, 32'h0, 5'd0, OP_LSL, 32'h0);
        req1_valid = 1'b1; req1_x = 32'h1; req1_sc = 5'd1; req1_op = OP_LSL;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stall1_saturated", 32'(stall1), 32'h0000_FFFF);
        chk("stall0_idle", 32'(stall0), 32'd0);
        step();
        do_reset(1);
        rsp0_ready = 1'b1;
        repeat (2) step();
`endif

        chk("single_ready_violations", 32'(both_ready_cnt), 32'd0);
        chk("exp0_drained", 32'(exp0.size()), 32'd0);
        chk("exp1_drained", 32'(exp1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
